uart_mmio_periph: RTL and testbench

//  Memory-mapped UART on the core's data bus, directly downstream of the core's bus_addr/bus_wrdata/bus_wren/bus_rden.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_mmio_periph_fifo.sv | 49 ++++
 rtl/uart_mmio_periph.sv | 215 +++++++++++++++++++++
 tb/tb_uart_mmio_periph.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, STATUS bit positions, FSM encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  // Register offsets within the 16-byte window (byte address, low two bits ignored)
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_RXDATA = 4'h4;
  localparam logic [3:0] UART_STATUS = 4'h8;
  localparam logic [3:0] UART_BAUD   = 4'hC;

  // STATUS bit positions
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_BUSY  = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_FRM_ERR  = 5;

  // Smallest usable divisor; the RX half-bit wait needs at least 2
  localparam logic [15:0] BAUD_MIN = 16'd2;

  typedef logic [1:0] tx_state_t;
  localparam tx_state_t TX_IDLE  = 2'd0;
  localparam tx_state_t TX_START = 2'd1;
  localparam tx_state_t TX_DATA  = 2'd2;
  localparam tx_state_t TX_STOP  = 2'd3;

  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

  // Divisor writes below the minimum are raised to it
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < BAUD_MIN) ? BAUD_MIN : d;
  endfunction

endpackage

// File: rtl/uart_mmio_periph_fifo.sv
// Generic synchronous FIFO with full/empty/count; pointers carry one extra wrap bit.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push is accepted when not full, or when full and a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; a pop frees the slot a simultaneous push needs when full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write, no reset needed since empty masks stale entries
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_mmio_periph.sv
// Memory-mapped 8N1 UART: TX FIFO + serialiser, RX synchroniser + deserialiser, 4-word register window.
// Latency: reads combinational; idle TXDATA write drives uart_tx low on the 2nd edge after the write edge.
// Backpressure: none on the bus; TX writes to a full FIFO are dropped and flagged, unread RX bytes are kept and overrun flagged.
module uart_mmio_periph
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
  parameter int          TX_DEPTH     = 8,
  parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic        bus_wren,
  input  logic        bus_rden,
  output logic [31:0] bus_rddata,
  output logic        bus_hit,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int CNT_W = $clog2(TX_DEPTH) + 1;

  // Bus decode
  logic [3:0] reg_off;
  logic wr_tx, wr_st, wr_baud, rx_pop;
  assign bus_hit = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off = {bus_addr[3:2], 2'b00};
  assign wr_tx   = bus_wren & bus_hit & (reg_off == UART_TXDATA);
  assign wr_st   = bus_wren & bus_hit & (reg_off == UART_STATUS);
  assign wr_baud = bus_wren & bus_hit & (reg_off == UART_BAUD);
  assign rx_pop  = bus_rden & bus_hit & (reg_off == UART_RXDATA);

  logic unused_bus;
  assign unused_bus = ^{bus_addr[1:0], bus_wrdata[31:16]};

  // Register state
  logic [15:0] baud_div;
  logic [7:0]  rx_byte;
  logic        rx_valid, tx_ovf, rx_ovr, frm_err;

  // TX FIFO
  logic             fifo_full, fifo_empty, tx_pop, tx_full, tx_busy;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .wdata (bus_wrdata[7:0]),
    .pop   (tx_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // TX path
  tx_state_t   tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;

  assign tx_pop  = ~fifo_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & (tx_cnt == 16'd0)));
  assign tx_full = (fifo_count == CNT_W'(TX_DEPTH));
  assign tx_busy = (tx_state != TX_IDLE) | ~fifo_empty;

  // TX FSM: each state/bit held for tx_div clocks; divisor latched at frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= BAUD_DIV_RST;
      tx_bit   <= '0;
      tx_sh    <= '0;
    end else if (tx_pop) begin
      tx_state <= TX_START;
      tx_div   <= baud_div;
      tx_cnt   <= baud_div - 16'd1;
      tx_sh    <= fifo_rdata;
    end else if (tx_state != TX_IDLE) begin
      if (tx_cnt != 16'd0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else begin
        tx_cnt <= tx_div - 16'd1;
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
          end
          TX_DATA: begin
            tx_sh <= {1'b0, tx_sh[7:1]};
            if (tx_bit == 3'd7) tx_state <= TX_STOP;
            else                tx_bit   <= tx_bit + 3'd1;
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // Registered line driver, one cycle behind the FSM so the pin never glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) uart_tx <= 1'b1;
    else begin
      case (tx_state)
        TX_START: uart_tx <= 1'b0;
        TX_DATA:  uart_tx <= tx_sh[0];
        default:  uart_tx <= 1'b1;
      endcase
    end
  end

  // RX path
  logic        rx_s1, rx_s2, rx_s3, rx_fall, rx_done;
  rx_state_t   rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else      {rx_s1, rx_s2, rx_s3} <= {uart_rx, rx_s1, rx_s2};
  end

  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_done = (rx_state == RX_STOP) & (rx_cnt == 16'd0);

  // RX FSM: half-bit wait to centre the start bit, then full-bit sampling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= BAUD_DIV_RST;
      rx_bit   <= '0;
      rx_sh    <= '0;
    end else if (rx_state == RX_IDLE) begin
      if (rx_fall) begin
        rx_state <= RX_START;
        rx_div   <= baud_div;
        rx_cnt   <= (baud_div >> 1) - 16'd1;
      end
    end else if (rx_cnt != 16'd0) begin
      rx_cnt <= rx_cnt - 16'd1;
    end else begin
      rx_cnt <= rx_div - 16'd1;
      case (rx_state)
        RX_START: begin
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          rx_bit   <= '0;
        end
        RX_DATA: begin
          rx_sh <= {rx_s2, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
          else                rx_bit   <= rx_bit + 3'd1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Register block: set beats clear, delivery beats pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_div <= BAUD_DIV_RST;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_ovr   <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= clamp_div(bus_wrdata[15:0]);

      if (rx_done && (!rx_valid || rx_pop)) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end

      if (wr_tx && fifo_full && !tx_pop)    tx_ovf <= 1'b1;
      else if (wr_st && bus_wrdata[ST_TX_OVF]) tx_ovf <= 1'b0;

      if (rx_done && rx_valid && !rx_pop)   rx_ovr <= 1'b1;
      else if (wr_st && bus_wrdata[ST_RX_OVR]) rx_ovr <= 1'b0;

      if (rx_done && !rx_s2)                frm_err <= 1'b1;
      else if (wr_st && bus_wrdata[ST_FRM_ERR]) frm_err <= 1'b0;
    end
  end

  // Combinational read mux
  always_comb begin
    logic [5:0] st;
    st              = '0;
    st[ST_TX_FULL]  = tx_full;
    st[ST_TX_BUSY]  = tx_busy;
    st[ST_RX_VALID] = rx_valid;
    st[ST_TX_OVF]   = tx_ovf;
    st[ST_RX_OVR]   = rx_ovr;
    st[ST_FRM_ERR]  = frm_err;
    bus_rddata      = '0;
    if (bus_hit) begin
      case (reg_off)
        UART_RXDATA: bus_rddata = {24'b0, rx_byte};
        UART_STATUS: bus_rddata = {26'b0, st};
        UART_BAUD:   bus_rddata = {16'b0, baud_div};
        default:     bus_rddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_periph.sv
// Directed bench for the memory-mapped UART with divisor 4.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_mmio_periph;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_BD = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wrdata = '0;
  logic        bus_wren = 1'b0;
  logic        bus_rden = 1'b0;
  logic [31:0] bus_rddata;
  logic        bus_hit;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  logic       cap_en = 1'b0;
  logic       cap_q[$];
  logic [7:0] exp_bytes[$];

  uart_mmio_periph #(
    .BASE_ADDR    (BASE),
    .TX_DEPTH     (8),
    .BAUD_DIV_RST (16'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_wrdata (bus_wrdata),
    .bus_wren   (bus_wren),
    .bus_rden   (bus_rden),
    .bus_rddata (bus_rddata),
    .bus_hit    (bus_hit),
    .uart_tx    (uart_tx),
    .uart_rx    (uart_rx)
  );

  always #5 clk = ~clk;

  // Line recorder, sampled mid-cycle
  always @(negedge clk) if (cap_en) cap_q.push_back(uart_tx);

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wrdata = d; bus_wren = 1'b1;
    @(negedge clk);
    bus_wren = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a;
    #1;
    d = bus_rddata;
  endtask

  task automatic bus_pop(output logic [31:0] d);
    bus_addr = A_RX; bus_rden = 1'b1;
    #1;
    d = bus_rddata;
    @(negedge clk);
    bus_rden = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Compare the recorded line against 8N1 frames of exp_bytes, 4 samples per bit, back to back
  task automatic expect_stream(input string tag);
    int s = -1;
    int errs;
    logic [7:0] b;
    logic e;
    for (int i = 0; i < cap_q.size(); i++) begin
      if (cap_q[i] == 1'b0) begin s = i; break; end
    end
    if (s < 0) begin
      check_vec({tag, " start bit seen"}, 0, 1);
      return;
    end
    for (int k = 0; k < exp_bytes.size(); k++) begin
      errs = 0;
      b = exp_bytes[k];
      for (int j = 0; j < 40; j++) begin
        if (j < 4)       e = 1'b0;
        else if (j < 36) e = b[(j-4)/4];
        else             e = 1'b1;
        if (s + k*40 + j >= cap_q.size() || cap_q[s + k*40 + j] !== e) errs++;
      end
      check_vec($sformatf("%s frame %0d bad samples", tag, k), errs, 0);
    end
    errs = 0;
    for (int j = 0; j < 4; j++) begin
      if (s + exp_bytes.size()*40 + j >= cap_q.size() || cap_q[s + exp_bytes.size()*40 + j] !== 1'b1) errs++;
    end
    check_vec({tag, " idle after"}, errs, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    check_vec("reset uart_tx", uart_tx, 1);
    rst = 1'b1;
    @(negedge clk);
    peek(A_ST, d); check_vec("reset STATUS", d, 0);
    peek(A_BD, d); check_vec("reset BAUD", d, 4);
    peek(A_RX, d); check_vec("reset RXDATA", d, 0);
    check_vec("hit in window", bus_hit, 1);
    @(negedge clk);

    // 1: single byte 0x55
    cap_q.delete(); cap_en = 1'b1;
    @(negedge clk);
    bus_wr(A_TX, 32'h55);
    peek(A_ST, d); check_vec("t1 busy after write", d[1], 1);
    @(negedge clk); check_vec("t1 line high 1st edge", uart_tx, 1);
    @(negedge clk); check_vec("t1 line low 2nd edge", uart_tx, 0);
    repeat (38) @(negedge clk);
    peek(A_ST, d); check_vec("t1 busy in stop", d[1], 1);
    @(negedge clk);
    peek(A_ST, d); check_vec("t1 busy dropped", d[1], 0);
    repeat (6) @(negedge clk);
    cap_en = 1'b0;
    exp_bytes = '{8'h55};
    expect_stream("t1");

    // 2: nine back-to-back writes, then overflow
    cap_q.delete(); cap_en = 1'b1; exp_bytes.delete();
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      exp_bytes.push_back(8'(i*29 + 3));
      bus_wr(A_TX, 32'(i*29 + 3));
    end
    peek(A_ST, d); check_vec("t2 full no ovf", d, 32'h03);
    bus_wr(A_TX, 32'hEE);
    peek(A_ST, d); check_vec("t2 ovf set", d, 32'h0B);
    repeat (370) @(negedge clk);
    cap_en = 1'b0;
    expect_stream("t2");
    peek(A_ST, d); check_vec("t2 drained", d, 32'h08);
    bus_wr(A_ST, 32'h08);
    peek(A_ST, d); check_vec("t2 ovf cleared", d, 0);

    // 3: receive 0xA3 and pop it
    rx_frame(8'hA3, 1'b1);
    peek(A_ST, d); check_vec("t3 rx_valid", d, 32'h04);
    peek(A_RX, d); check_vec("t3 RXDATA", d, 32'hA3);
    bus_pop(d);    check_vec("t3 pop data", d, 32'hA3);
    peek(A_ST, d); check_vec("t3 rx_valid cleared", d, 0);

    // 4: overrun, glitch, framing error
    rx_frame(8'h3C, 1'b1);
    rx_frame(8'hC5, 1'b1);
    peek(A_ST, d); check_vec("t4 overrun", d, 32'h14);
    peek(A_RX, d); check_vec("t4 first byte kept", d, 32'h3C);
    bus_wr(A_ST, 32'h38);
    bus_pop(d);
    peek(A_ST, d); check_vec("t4 flags cleared", d, 0);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    peek(A_ST, d); check_vec("t4 glitch status", d, 0);
    peek(A_RX, d); check_vec("t4 glitch RXDATA", d, 32'h3C);
    rx_frame(8'h81, 1'b0);
    peek(A_ST, d); check_vec("t4 frm_err", d, 32'h24);
    peek(A_RX, d); check_vec("t4 frm_err byte", d, 32'h81);
    bus_wr(A_ST, 32'h38);
    bus_pop(d);

    // 5: out-of-window access and divisor clamp
    bus_addr = BASE + 32'h10; bus_wrdata = 32'h12; bus_wren = 1'b1; bus_rden = 1'b1;
    #1;
    check_vec("t5 no hit", bus_hit, 0);
    check_vec("t5 rddata zero", bus_rddata, 0);
    @(negedge clk);
    bus_wren = 1'b0; bus_rden = 1'b0;
    repeat (2) @(negedge clk);
    peek(A_ST, d); check_vec("t5 no side effect", d, 0);
    bus_wr(A_BD, 32'h0);
    peek(A_BD, d); check_vec("t5 baud 0 -> 2", d, 2);
    bus_wr(A_BD, 32'h1);
    peek(A_BD, d); check_vec("t5 baud 1 -> 2", d, 2);
    bus_wr(A_BD, 32'h4);
    peek(A_BD, d); check_vec("t5 baud 4", d, 4);

    // 6: reset mid-frame
    bus_wr(A_TX, 32'hF0);
    bus_wr(A_TX, 32'h0F);
    bus_wr(A_TX, 32'h33);
    for (int i = 0; i < 10 && uart_tx !== 1'b0; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    check_vec("t6 line low before reset", uart_tx, 0);
    #2 rst = 1'b0;
    #1 check_vec("t6 async line high", uart_tx, 1);
    peek(A_ST, d); check_vec("t6 STATUS in reset", d, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    peek(A_ST, d); check_vec("t6 STATUS after release", d, 0);
    cap_q.delete(); cap_en = 1'b1;
    @(negedge clk);
    bus_wr(A_TX, 32'h96);
    repeat (50) @(negedge clk);
    cap_en = 1'b0;
    exp_bytes = '{8'h96};
    expect_stream("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
